operand_handler_pipe: RTL and testbench
=======================================

OPERAND_HANDLER_PIPE -- requirements
Module: operand_handler_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand and output width in bits (legal range 16..64).
REQ-002 SHALL provide parameter IMM_W, default 16, immediate width in bits (legal range 1..DATA_W/2).
REQ-003 SHALL provide parameter LINK_OFF, default 8, byte offset added to PC in link mode.
REQ-004 SHALL run on one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  upstream request valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-009 SHALL have port sel  input  3  operand source select.
REQ-010 SHALL have ports pb, hi, lo, pc  input  DATA_W each  candidate operands.
REQ-011 SHALL have port imm  input  IMM_W  instruction immediate.
REQ-012 SHALL have port hilo_busy  input  1  multiply/divide unit still writing HI/LO.
REQ-013 SHALL have port out_valid  output  1  n_out holds a valid operand.
REQ-014 SHALL have port out_ready  input  1  downstream consumes the operand.
REQ-015 SHALL have port n_out  output  DATA_W  selected operand.
REQ-016 SHALL have port stall_cnt  output  16  count of hazard-stalled cycles.

Function
REQ-017 SHALL compute the operand at acceptance per sel:
- 000 pb
- 001 hi
- 010 lo
- 011 pc
- 100 imm sign-extended to DATA_W
- 101 imm zero-extended to DATA_W
- 110 imm placed in bits [DATA_W-1:DATA_W-IMM_W], zeros below
- 111 pc + LINK_OFF, modulo 2^DATA_W
REQ-018 SHALL sample all inputs only in the acceptance cycle; later changes to pb/hi/lo/pc/imm SHALL NOT alter stored entries.
REQ-019 SHALL buffer results in a 2-entry FIFO; n_out/out_valid SHALL reflect the oldest entry.
REQ-020 SHALL accept a request iff in_valid && in_ready at a rising edge.
REQ-021 SHALL drive in_ready = (count < 2) && !hazard, where hazard = hilo_busy && (sel == 001 || sel == 010).
REQ-022 SHALL treat in_ready's dependence on sel and hilo_busy as combinational; in_ready SHALL NOT depend on out_ready.
REQ-023 SHALL pop the oldest entry iff out_valid && out_ready at a rising edge.
REQ-024 SHALL give 1-cycle latency: a request accepted into an empty FIFO makes out_valid high in the next cycle.
REQ-025 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-026 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-027 SHALL, when count = 2 and a pop occurs, leave in_ready low that cycle; the freed slot becomes available in the next cycle.
REQ-028 SHALL keep n_out and out_valid stable while out_valid && !out_ready.
REQ-029 SHALL hold n_out at its last value when the FIFO empties, with out_valid low.
REQ-030 SHALL increment stall_cnt each cycle in which in_valid && hazard && count < 2.
REQ-031 SHALL saturate stall_cnt at 16'hFFFF with no wrap.
REQ-032 SHALL NOT count full-FIFO stalls in stall_cnt.

Reset
REQ-033 SHALL, while rst_n is low, force count = 0, out_valid = 0, n_out = 0 and stall_cnt = 0 without waiting for a clock edge.
REQ-034 SHALL hold in_ready = 0 while rst_n is low.
REQ-035 SHALL discard buffered entries on reset mid-operation; no stale operand SHALL appear after release.
REQ-036 SHALL accept requests from the first rising edge after rst_n deasserts.

Verification
REQ-037 Bench SHALL cover all 8 sel codes with pb=32'h11111111, hi=32'h22222222, lo=32'h33333333, pc=32'h00400000, imm=16'h8001, out_ready=1:
- 000 -> 32'h11111111
- 001 -> 32'h22222222
- 010 -> 32'h33333333
- 011 -> 32'h00400000
- 100 -> 32'hFFFF8001
- 101 -> 32'h00008001
- 110 -> 32'h80010000
- 111 -> 32'h00400008
Each result SHALL appear one cycle after acceptance.
REQ-038 Bench SHALL cover hazard: hilo_busy=1, sel=001, in_valid=1 for 5 cycles -> in_ready=0 and stall_cnt=5; drop hilo_busy -> accepted, next cycle n_out=hi.
REQ-039 Bench SHALL cover backpressure: out_ready=0, push 3 requests (sel=000, pb=1,2,3) -> two accepted, in_ready=0, n_out=1 held; raise out_ready -> outputs 1,2,3 in order.
REQ-040 Bench SHALL cover wrap: sel=111, pc=32'hFFFFFFFC -> n_out=32'h00000004.
REQ-041 Bench SHALL cover reset mid-operation: two entries buffered, assert rst_n low mid-cycle -> out_valid=0, n_out=0, stall_cnt=0 immediately; after release the first output is the next new request.
REQ-042 Bench SHALL cover stall_cnt saturation: hold the hazard for 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/operand_handler_pipe.sv
// Operand handler: selects one of eight operand sources at acceptance time,
// buffers the result in a 2-entry FIFO and counts cycles lost to HI/LO hazards.
module operand_handler_pipe #(
  parameter int          DATA_W   = 32,
  parameter int          IMM_W    = 16,
  parameter int unsigned LINK_OFF = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] pb,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              hilo_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] n_out,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [2:0] {
    SEL_PB   = 3'b000,
    SEL_HI   = 3'b001,
    SEL_LO   = 3'b010,
    SEL_PC   = 3'b011,
    SEL_SEXT = 3'b100,
    SEL_ZEXT = 3'b101,
    SEL_UPPR = 3'b110,
    SEL_LINK = 3'b111
  } sel_e;

  // Operand mux. The immediate is treated as a signed quantity for the
  // sign-extended form; the link form wraps modulo 2^DATA_W naturally.
  function automatic logic [DATA_W-1:0] f_operand(
    input logic [2:0]        a_sel,
    input logic [DATA_W-1:0] a_pb,
    input logic [DATA_W-1:0] a_hi,
    input logic [DATA_W-1:0] a_lo,
    input logic [DATA_W-1:0] a_pc,
    input logic [IMM_W-1:0]  a_imm
  );
    logic signed [IMM_W-1:0]  imm_s;
    logic signed [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0]        res;
    imm_s    = signed'(a_imm);
    imm_sext = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
    case (sel_e'(a_sel))
      SEL_PB:   res = a_pb;
      SEL_HI:   res = a_hi;
      SEL_LO:   res = a_lo;
      SEL_PC:   res = a_pc;
      SEL_SEXT: res = imm_sext;
      SEL_ZEXT: res = {{(DATA_W-IMM_W){1'b0}}, a_imm};
      SEL_UPPR: res = {a_imm, {(DATA_W-IMM_W){1'b0}}};
      SEL_LINK: res = a_pc + DATA_W'(LINK_OFF);
      default:  res = a_pb;
    endcase
    return res;
  endfunction

  // Saturating increment for the 16-bit stall counter.
  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_head_p1;
  logic [DATA_W-1:0] r_tail_p1;
  logic [15:0]       r_stall_cnt;

  logic              w_hazard;
  logic              w_not_full;
  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_stall;
  logic [DATA_W-1:0] w_operand_p0;

  // Stage p0: operand selection and handshake decode.
  // in_ready is gated by rst_n so the block refuses requests during reset.
  always_comb begin
    w_hazard     = hilo_busy && ((sel == SEL_HI) || (sel == SEL_LO));
    w_not_full   = (r_count != 2'd2);
    w_in_ready   = rst_n && w_not_full && !w_hazard;
    w_push       = in_valid && w_in_ready;
    w_pop        = (r_count != 2'd0) && out_ready;
    w_stall      = in_valid && w_hazard && w_not_full;
    w_operand_p0 = f_operand(sel, pb, hi, lo, pc, imm);
  end

  // Stage p1: head entry drives n_out directly; it keeps its value when the
  // FIFO drains so n_out holds the last operand. A pop from a full FIFO
  // shifts the tail forward; otherwise a push lands in the head whenever the
  // head is empty or being consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 2'd0;
      r_head_p1 <= '0;
    end else begin
      if (w_pop && (r_count == 2'd2)) begin
        r_head_p1 <= r_tail_p1;
      end else if (w_push && ((r_count == 2'd0) || w_pop)) begin
        r_head_p1 <= w_operand_p0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Second FIFO slot: filled only when a push arrives behind an unconsumed
  // head. Its contents are meaningless while r_count < 2, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && (r_count == 2'd1) && !w_pop) begin
      r_tail_p1 <= w_operand_p0;
    end
  end

  // Hazard stall counter: counts only HI/LO hazard cycles, never full stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall) begin
      r_stall_cnt <= f_sat_inc(r_stall_cnt);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign n_out     = r_head_p1;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_handler_pipe.sv
// Directed bench for operand_handler_pipe.
module tb_operand_handler_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [31:0] pb, hi, lo, pc;
  logic [15:0] imm;
  logic        hilo_busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] n_out;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_sel [8];

  operand_handler_pipe #(.DATA_W(32), .IMM_W(16), .LINK_OFF(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .pb(pb), .hi(hi), .lo(lo), .pc(pc), .imm(imm),
    .hilo_busy(hilo_busy), .out_valid(out_valid), .out_ready(out_ready),
    .n_out(n_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_sel[0] = 32'h11111111;
    exp_sel[1] = 32'h22222222;
    exp_sel[2] = 32'h33333333;
    exp_sel[3] = 32'h00400000;
    exp_sel[4] = 32'hFFFF8001;
    exp_sel[5] = 32'h00008001;
    exp_sel[6] = 32'h80010000;
    exp_sel[7] = 32'h00400008;

    rst_n = 1'b0; in_valid = 1'b0; sel = 3'd0; hilo_busy = 1'b0; out_ready = 1'b1;
    pb = 32'h11111111; hi = 32'h22222222; lo = 32'h33333333; pc = 32'h00400000;
    imm = 16'h8001;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_n_out", n_out, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // All eight select codes, back-to-back with out_ready high
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s); in_valid = 1'b1;
      #1;
      chk("sel_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("sel_valid", 32'(out_valid), 32'd1);
      chk($sformatf("sel%0d_n_out", s), n_out, exp_sel[s]);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold", n_out, 32'h00400008);

    // Link wrap-around
    sel = 3'd7; pc = 32'hFFFFFFFC; in_valid = 1'b1;
    tick();
    chk("wrap_n_out", n_out, 32'h00000004);
    in_valid = 1'b0;
    tick();

    // Hazard on non-HI/LO source is not a hazard
    hilo_busy = 1'b1; sel = 3'd0;
    #1;
    chk("nohaz_in_ready", 32'(in_ready), 32'd1);
    sel = 3'd2;
    #1;
    chk("haz_lo_in_ready", 32'(in_ready), 32'd0);

    // Hazard: 5 stalled cycles on HI
    sel = 3'd1; in_valid = 1'b1;
    #1;
    chk("haz_in_ready", 32'(in_ready), 32'd0);
    repeat (5) tick();
    chk("haz_stall5", 32'(stall_cnt), 32'd5);
    chk("haz_no_valid", 32'(out_valid), 32'd0);
    hilo_busy = 1'b0;
    #1;
    chk("haz_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("haz_valid", 32'(out_valid), 32'd1);
    chk("haz_n_out", n_out, 32'h22222222);
    chk("haz_stall_kept", 32'(stall_cnt), 32'd5);
    in_valid = 1'b0;
    tick();

    // Backpressure: three requests against a stalled consumer
    out_ready = 1'b0; sel = 3'd0; pb = 32'd1; in_valid = 1'b1;
    tick();
    chk("bp_n_out1", n_out, 32'd1);
    pb = 32'd2;
    tick();
    pb = 32'd3;
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_n_out", n_out, 32'd1);
    // Hazard while full must not count
    sel = 3'd1; hilo_busy = 1'b1;
    tick();
    chk("bp_full_nocount", 32'(stall_cnt), 32'd5);
    sel = 3'd0; hilo_busy = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_pop_full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_out1_popped", n_out, 32'd2);
    chk("bp_freed_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    chk("bp_out3", n_out, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_empty_hold", n_out, 32'd3);

    // Reset mid-operation with two entries buffered
    out_ready = 1'b0; pb = 32'h000000AA; in_valid = 1'b1;
    tick();
    pb = 32'h000000BB;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_n_out", n_out, 32'd0);
    chk("mrst_stall", 32'(stall_cnt), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1; pb = 32'h000000CC; sel = 3'd0; in_valid = 1'b1;
    tick();
    chk("mrst_first_valid", 32'(out_valid), 32'd1);
    chk("mrst_first_out", n_out, 32'h000000CC);
    in_valid = 1'b0;
    tick();
    chk("mrst_no_stale", 32'(out_valid), 32'd0);

    // Stall counter saturation over 70000 hazard cycles
    hilo_busy = 1'b1; sel = 3'd2; in_valid = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
    repeat (4466) tick();
    chk("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
    in_valid = 1'b0; hilo_busy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
